// File: rtl/pos_decode.sv
// pos_decode: averages accumulated X/Y coordinate sums over a neighbour count with a
// bit-serial restoring divider. Define POS_DECODE_ROUND_EN for round-half-up averaging.
module pos_decode #(
    parameter int LBL_LEN  = 10,
    parameter int CSUM_LEN = 7,
    parameter int CNT_LEN  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CSUM_LEN-1:0] inXSum,
    input  logic [CSUM_LEN-1:0] inYSum,
    input  logic [CNT_LEN-1:0]  inCount,
    input  logic                inValid,
    output logic                inReady,
    output logic [LBL_LEN-1:0]  outL,
    output logic                outErr,
    output logic                outValid,
    input  logic                inAck
);
    // state  | meaning
    // IDLE   | waiting for a request, inReady high
    // DIVIDE | one quotient bit per cycle for X and Y
    // DONE   | result presented until inAck
    typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_t;

    localparam int DW = CSUM_LEN + 1;
    localparam int HW = LBL_LEN / 2;
    localparam int CW = $clog2(DW);
    localparam int SW = (DW > HW) ? DW : HW;
    localparam logic [SW-1:0] QMAX = SW'((1 << HW) - 1);

    state_t               state_q, state_d;
    logic [DW-1:0]        xdiv_q, xdiv_d, ydiv_q, ydiv_d;
    logic [CNT_LEN-1:0]   xrem_q, xrem_d, yrem_q, yrem_d;
    logic [CNT_LEN-1:0]   divisor_q, divisor_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [LBL_LEN-1:0]   outL_q, outL_d;
    logic                 outErr_q, outErr_d;
    logic [DW-1:0]        xdvd, ydvd;

`ifdef POS_DECODE_ROUND_EN
    assign xdvd = {1'b0, inXSum} + DW'(inCount >> 1);
    assign ydvd = {1'b0, inYSum} + DW'(inCount >> 1);
`else
    assign xdvd = {1'b0, inXSum};
    assign ydvd = {1'b0, inYSum};
`endif

    // Dividend shifts out MSB-first while quotient bits shift in at the LSB.
    function automatic logic [CNT_LEN+DW-1:0] div_step(input logic [CNT_LEN-1:0] rem,
                                                       input logic [DW-1:0]      dvd,
                                                       input logic [CNT_LEN-1:0] dvs);
        logic [CNT_LEN:0]   trial;
        logic [CNT_LEN-1:0] diff;
        trial = {rem, dvd[DW-1]};
        diff  = trial[CNT_LEN-1:0] - dvs;
        if (trial >= {1'b0, dvs})
            return {diff, dvd[DW-2:0], 1'b1};
        else
            return {trial[CNT_LEN-1:0], dvd[DW-2:0], 1'b0};
    endfunction

    function automatic logic [HW-1:0] sat(input logic [DW-1:0] q);
        logic [SW-1:0] qw;
        qw = SW'(q);
        return (qw > QMAX) ? QMAX[HW-1:0] : qw[HW-1:0];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            xdiv_q    <= '0;
            ydiv_q    <= '0;
            xrem_q    <= '0;
            yrem_q    <= '0;
            divisor_q <= '0;
            cnt_q     <= '0;
            outL_q    <= '0;
            outErr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            xdiv_q    <= xdiv_d;
            ydiv_q    <= ydiv_d;
            xrem_q    <= xrem_d;
            yrem_q    <= yrem_d;
            divisor_q <= divisor_d;
            cnt_q     <= cnt_d;
            outL_q    <= outL_d;
            outErr_q  <= outErr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (inValid) state_d = DIVIDE;
            DIVIDE:  if (cnt_q == '0) state_d = DONE;
            DONE:    if (inAck) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A zero count spends a single DIVIDE cycle so the error result lands one edge after accept.
    always_comb begin
        xdiv_d    = xdiv_q;
        ydiv_d    = ydiv_q;
        xrem_d    = xrem_q;
        yrem_d    = yrem_q;
        divisor_d = divisor_q;
        cnt_d     = cnt_q;
        outL_d    = outL_q;
        outErr_d  = outErr_q;
        case (state_q)
            IDLE: begin
                if (inValid) begin
                    xdiv_d    = xdvd;
                    ydiv_d    = ydvd;
                    xrem_d    = '0;
                    yrem_d    = '0;
                    divisor_d = inCount;
                    cnt_d     = (inCount == '0) ? '0 : CW'(DW - 1);
                end
            end
            DIVIDE: begin
                if (divisor_q != '0) begin
                    {xrem_d, xdiv_d} = div_step(xrem_q, xdiv_q, divisor_q);
                    {yrem_d, ydiv_d} = div_step(yrem_q, ydiv_q, divisor_q);
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    if (divisor_q == '0) begin
                        outL_d   = '0;
                        outErr_d = 1'b1;
                    end else begin
                        outL_d   = LBL_LEN'({sat(xdiv_d), sat(ydiv_d)});
                        outErr_d = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        inReady  = (state_q == IDLE);
        outValid = (state_q == DONE);
        outL     = outL_q;
        outErr   = outErr_q;
    end

endmodule

// File: tb/tb_pos_decode.sv
// tb_pos_decode: directed and randomized requests checked against an arithmetic average model.
module tb_pos_decode;
    localparam int LBL_LEN  = 10;
    localparam int CSUM_LEN = 7;
    localparam int CNT_LEN  = 4;
    localparam int HMAX     = (1 << (LBL_LEN / 2)) - 1;
    localparam int LAT      = CSUM_LEN + 1;

    logic                clk = 1'b0;
    logic                rst;
    logic [CSUM_LEN-1:0] inXSum;
    logic [CSUM_LEN-1:0] inYSum;
    logic [CNT_LEN-1:0]  inCount;
    logic                inValid;
    logic                inReady;
    logic [LBL_LEN-1:0]  outL;
    logic                outErr;
    logic                outValid;
    logic                inAck;

    int n_chk  = 0;
    int n_fail = 0;

    pos_decode #(.LBL_LEN(LBL_LEN), .CSUM_LEN(CSUM_LEN), .CNT_LEN(CNT_LEN)) dut (
        .clk(clk), .rst(rst), .inXSum(inXSum), .inYSum(inYSum), .inCount(inCount),
        .inValid(inValid), .inReady(inReady), .outL(outL), .outErr(outErr),
        .outValid(outValid), .inAck(inAck)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int unsigned avg(input int unsigned s, input int unsigned c);
        int unsigned q;
`ifdef POS_DECODE_ROUND_EN
        q = (s + c / 2) / c;
`else
        q = s / c;
`endif
        return (q > HMAX) ? HMAX : q;
    endfunction

    task automatic run_req(input int x, input int y, input int c, input int hold);
        int                 lat;
        logic [LBL_LEN-1:0] exp_l;
        logic               exp_e;
        exp_e = (c == 0);
        exp_l = exp_e ? '0 : LBL_LEN'(avg(x, c) * (HMAX + 1) + avg(y, c));
        @(negedge clk);
        inXSum  = CSUM_LEN'(x);
        inYSum  = CSUM_LEN'(y);
        inCount = CNT_LEN'(c);
        inValid = 1'b1;
        check("ready_idle", inReady, 1);
        @(posedge clk);
        #1;
        inValid = 1'b0;
        lat = 0;
        while (!outValid && lat < 4 * LAT) begin
            check("busy_ready", inReady, 0);
            inValid = 1'($urandom_range(0, 1));
            inAck   = 1'($urandom_range(0, 1));
            inXSum  = CSUM_LEN'($urandom);
            inYSum  = CSUM_LEN'($urandom);
            inCount = CNT_LEN'($urandom);
            @(posedge clk);
            #1;
            lat++;
        end
        inValid = 1'b0;
        inAck   = 1'b0;
        check("latency", lat, exp_e ? 1 : LAT);
        check("outL", outL, exp_l);
        check("outErr", outErr, exp_e);
        for (int i = 0; i < hold; i++) begin
            inValid = 1'($urandom_range(0, 1));
            inXSum  = CSUM_LEN'($urandom);
            inCount = CNT_LEN'($urandom);
            @(posedge clk);
            #1;
            check("hold_valid", outValid, 1);
            check("hold_outL", outL, exp_l);
            check("hold_ready", inReady, 0);
        end
        inValid = 1'b1;
        inAck   = 1'b1;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        inAck   = 1'b0;
        check("ack_ready", inReady, 1);
        check("ack_valid", outValid, 0);
        check("keep_outL", outL, exp_l);
        check("keep_outErr", outErr, exp_e);
    endtask

    initial begin
        logic seen;
        rst     = 1'b1;
        inXSum  = '0;
        inYSum  = '0;
        inCount = '0;
        inValid = 1'b0;
        inAck   = 1'b0;
        #12;
        check("rst_ready", inReady, 1);
        check("rst_valid", outValid, 0);
        check("rst_outL", outL, 0);
        check("rst_outErr", outErr, 0);
        @(negedge clk);
        rst = 1'b0;

        run_req(40, 21, 4, 5);
        run_req(40, 23, 4, 0);
        run_req(99, 17, 0, 2);
        run_req(127, 3, 1, 1);

        // abandon a request three cycles into the division
        @(negedge clk);
        inXSum  = CSUM_LEN'(100);
        inYSum  = CSUM_LEN'(50);
        inCount = CNT_LEN'(3);
        inValid = 1'b1;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_ready", inReady, 1);
        check("mid_rst_valid", outValid, 0);
        check("mid_rst_outL", outL, 0);
        check("mid_rst_outErr", outErr, 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (outValid) seen = 1'b1;
        end
        check("rst_abandon", seen, 0);
        run_req(100, 50, 3, 1);

        for (int k = 0; k < 40; k++)
            run_req($urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, 15),
                    $urandom_range(0, 3));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
